alu_issue_unit: RTL and testbench

- Sequencer that sits directly upstream of the 4-bit combinational ALU and also consumes its result.
- Accepts one instruction at a time over a valid/ready handshake and reads two operands from an internal 4-entry register file.
- Drives the ALU's op/a/b inputs from registers, captures the ALU's c/carry, and writes the result back to the register file while updating flags.
- Only one instruction is in flight at a time.

---
 rtl/alu_issue_if.sv | 13 +
 rtl/alu_issue_unit.sv | 84 ++++++++
 tb/tb_alu_issue_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction valid/ready handshake into the ALU issue unit.
interface alu_issue_if #(parameter int DATA_W = 4);
   logic              in_valid;
   logic              in_ready;
   logic              in_load;
   logic [2:0]        in_op;
   logic [1:0]        in_rd;
   logic [1:0]        in_rs1;
   logic [1:0]        in_rs2;
   logic [DATA_W-1:0] in_imm;
   modport master (output in_valid, in_load, in_op, in_rd, in_rs1, in_rs2, in_imm, input in_ready);
   modport slave (input in_valid, in_load, in_op, in_rd, in_rs1, in_rs2, in_imm, output in_ready);
endinterface

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: one-at-a-time sequencer feeding an external ALU and writing back to a 4-entry regfile.
// Optional ALU_OVF_EN adds a signed-overflow flag updated by ADD.
module alu_issue_unit #(
   parameter int DATA_W = 4,
   parameter int NREG   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_issue_if.slave        issue,
   output logic [2:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_c,
   input  logic              alu_carry,
   output logic              done,
   output logic              carry_flag,
   output logic              zero_flag,
`ifdef ALU_OVF_EN
   output logic              ovf_flag,
`endif
   input  logic [1:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);
   typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;
   state_t state, state_nx;
   logic [DATA_W-1:0] rf [NREG];
   logic [DATA_W-1:0] res;
   logic              cap_carry;
   logic              is_load;
   logic [1:0]        rd_q;
   logic              accept;
   always_comb begin
      issue.in_ready = state == IDLE;
      done           = state == WRITE;
      accept         = issue.in_ready && issue.in_valid;
      state_nx       = state == IDLE ? (issue.in_valid ? (issue.in_load ? WRITE : EXEC) : IDLE)
                     : state == EXEC ? WRITE : IDLE;
   end
   assign dbg_data = rf[dbg_sel];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
         alu_op     <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         res        <= '0;
         cap_carry  <= 1'b0;
         is_load    <= 1'b0;
         rd_q       <= '0;
         carry_flag <= 1'b0;
         zero_flag  <= 1'b0;
`ifdef ALU_OVF_EN
         ovf_flag   <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         if (accept) begin
            is_load <= issue.in_load;
            rd_q    <= issue.in_rd;
            if (issue.in_load) res <= issue.in_imm;
            else begin
               alu_op <= issue.in_op;
               alu_a  <= rf[issue.in_rs1];
               alu_b  <= rf[issue.in_rs2];
            end
         end
         if (state == EXEC) begin
            res       <= alu_c;
            cap_carry <= alu_carry;
         end
         // alu_op still holds the opcode of the instruction being retired
         if (state == WRITE) begin
            rf[rd_q]  <= res;
            zero_flag <= res == '0;
            if (!is_load && alu_op[2:1] == 2'b00) carry_flag <= cap_carry;
`ifdef ALU_OVF_EN
            if (!is_load && alu_op == 3'd0)
               ovf_flag <= (alu_a[DATA_W-1] == alu_b[DATA_W-1]) && (res[DATA_W-1] != alu_a[DATA_W-1]);
`endif
         end
      end
   end
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: directed checks of the issue unit with a behavioural 4-bit ALU attached.
module tb_alu_issue_unit;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] alu_op;
   logic [3:0] alu_a, alu_b, alu_c, dbg_data;
   logic       alu_carry, done, carry_flag, zero_flag;
   logic [1:0] dbg_sel = 2'd0;
   logic [4:0] ext;
`ifdef ALU_OVF_EN
   logic       ovf_flag;
`endif
   int checks = 0;
   int failures = 0;
   alu_issue_if #(.DATA_W(4)) bus();
   alu_issue_unit #(.DATA_W(4), .NREG(4)) dut (
      .clk(clk), .rst_n(rst_n), .issue(bus),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_carry(alu_carry),
      .done(done), .carry_flag(carry_flag), .zero_flag(zero_flag),
`ifdef ALU_OVF_EN
      .ovf_flag(ovf_flag),
`endif
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );
   always #5 clk = ~clk;
   // Reference ALU: bit 4 of the 5-bit result is the carry (borrow for SUB)
   always_comb begin
      ext = '0;
      case (alu_op)
         3'd0: ext = {1'b0, alu_a} + {1'b0, alu_b};
         3'd1: ext = {1'b0, alu_a} - {1'b0, alu_b};
         3'd2: ext = {1'b0, alu_a & alu_b};
         3'd3: ext = {1'b0, alu_a | alu_b};
         3'd4: ext = {1'b0, ~alu_a};
         3'd5: ext = {1'b0, alu_a ^ alu_b};
         3'd6: ext = {1'b0, ~(alu_a & alu_b)};
         default: ext = {1'b0, ~(alu_a | alu_b)};
      endcase
   end
   assign alu_c = ext[3:0];
   assign alu_carry = ext[4];
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic reg_chk(input string tag, input logic [1:0] r, input logic [3:0] exp);
      dbg_sel = r;
      #1;
      chk(tag, {4'd0, dbg_data}, {4'd0, exp});
   endtask
   task automatic do_load(input logic [1:0] rd, input logic [3:0] imm);
      bus.in_valid = 1'b1; bus.in_load = 1'b1; bus.in_rd = rd; bus.in_imm = imm;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("load_done", {7'd0, done}, 8'd1);
      @(posedge clk); #1;
      chk("load_done_end", {7'd0, done}, 8'd0);
      chk("load_ready", {7'd0, bus.in_ready}, 8'd1);
   endtask
   task automatic do_alu(input logic [2:0] op, input logic [1:0] rd, rs1, rs2, input logic [3:0] ea, eb);
      bus.in_valid = 1'b1; bus.in_load = 1'b0; bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("exec_op", {5'd0, alu_op}, {5'd0, op});
      chk("exec_a", {4'd0, alu_a}, {4'd0, ea});
      chk("exec_b", {4'd0, alu_b}, {4'd0, eb});
      chk("exec_nodone", {7'd0, done}, 8'd0);
      @(posedge clk); #1;
      chk("alu_done", {7'd0, done}, 8'd1);
      @(posedge clk); #1;
      chk("alu_ready", {7'd0, bus.in_ready}, 8'd1);
   endtask
   initial begin
      int first, second, n_done, n_busy;
      bus.in_valid = 1'b0; bus.in_load = 1'b0; bus.in_op = '0; bus.in_rd = '0;
      bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready", {7'd0, bus.in_ready}, 8'd1);
      chk("rst_done", {7'd0, done}, 8'd0);
      chk("rst_carry", {7'd0, carry_flag}, 8'd0);
      chk("rst_zero", {7'd0, zero_flag}, 8'd0);
      for (int i = 0; i < 4; i++) reg_chk("rst_reg", 2'(i), 4'd0);
      do_load(2'd0, 4'b1000);
      do_load(2'd1, 4'b0100);
      reg_chk("r0", 2'd0, 4'b1000);
      reg_chk("r1", 2'd1, 4'b0100);
      chk("load_zero", {7'd0, zero_flag}, 8'd0);
      do_alu(3'd0, 2'd2, 2'd0, 2'd1, 4'b1000, 4'b0100);
      reg_chk("add_r2", 2'd2, 4'b1100);
      chk("add_carry", {7'd0, carry_flag}, 8'd0);
      chk("add_zero", {7'd0, zero_flag}, 8'd0);
      do_alu(3'd0, 2'd3, 2'd0, 2'd0, 4'b1000, 4'b1000);
      reg_chk("add_wrap_r3", 2'd3, 4'b0000);
      chk("add_wrap_carry", {7'd0, carry_flag}, 8'd1);
      chk("add_wrap_zero", {7'd0, zero_flag}, 8'd1);
      do_alu(3'd2, 2'd3, 2'd0, 2'd1, 4'b1000, 4'b0100);
      reg_chk("and_r3", 2'd3, 4'b0000);
      chk("and_zero", {7'd0, zero_flag}, 8'd1);
      chk("and_carry_hold", {7'd0, carry_flag}, 8'd1);
      do_alu(3'd4, 2'd3, 2'd0, 2'd1, 4'b1000, 4'b0100);
      reg_chk("not_r3", 2'd3, 4'b0111);
      chk("not_zero", {7'd0, zero_flag}, 8'd0);
      chk("not_carry_hold", {7'd0, carry_flag}, 8'd1);
      do_load(2'd3, 4'b0000);
      chk("load0_zero", {7'd0, zero_flag}, 8'd1);
      chk("load0_carry_hold", {7'd0, carry_flag}, 8'd1);
      do_alu(3'd1, 2'd3, 2'd0, 2'd1, 4'b1000, 4'b0100);
      reg_chk("sub_r3", 2'd3, 4'b0100);
      chk("sub_carry", {7'd0, carry_flag}, 8'd0);
      do_alu(3'd5, 2'd1, 2'd1, 2'd0, 4'b0100, 4'b1000);
      reg_chk("xor_hazard_r1", 2'd1, 4'b1100);
      do_load(2'd1, 4'b0100);
      // back-to-back ADD r3=r3+r3 with in_valid held: 4+4=8, then 8+8 wraps to 0
      first = -1; second = -1; n_done = 0; n_busy = 0;
      bus.in_valid = 1'b1; bus.in_load = 1'b0; bus.in_op = 3'd0;
      bus.in_rd = 2'd3; bus.in_rs1 = 2'd3; bus.in_rs2 = 2'd3;
      for (int c = 0; c < 8; c++) begin
         if (!bus.in_ready) n_busy++;
         if (bus.in_ready && bus.in_valid) begin
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
         @(posedge clk); #1;
         if (second >= 0) bus.in_valid = 1'b0;
         if (done) n_done++;
      end
      chk("b2b_first", 8'(first), 8'd0);
      chk("b2b_gap", 8'(second - first), 8'd3);
      chk("b2b_done_count", 8'(n_done), 8'd2);
      chk("b2b_busy", 8'(n_busy), 8'd4);
      reg_chk("b2b_r3", 2'd3, 4'b0000);
      chk("b2b_carry", {7'd0, carry_flag}, 8'd1);
      chk("b2b_zero", {7'd0, zero_flag}, 8'd1);
      // reset during EXEC of ADD r2 (r2 = 1100)
      reg_chk("pre_rst_r2", 2'd2, 4'b1100);
      bus.in_valid = 1'b1; bus.in_load = 1'b0; bus.in_op = 3'd0;
      bus.in_rd = 2'd2; bus.in_rs1 = 2'd0; bus.in_rs2 = 2'd1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n_done = 0;
      rst_n = 1'b0;
      #1;
      if (done) n_done++;
      reg_chk("mid_rst_r2", 2'd2, 4'b0000);
      chk("mid_rst_carry", {7'd0, carry_flag}, 8'd0);
      chk("mid_rst_zero", {7'd0, zero_flag}, 8'd0);
      chk("mid_rst_alu_a", {4'd0, alu_a}, 8'd0);
      repeat (2) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      chk("mid_rst_nodone", 8'(n_done), 8'd0);
      chk("mid_rst_ready", {7'd0, bus.in_ready}, 8'd1);
      reg_chk("mid_rst_r2_after", 2'd2, 4'b0000);
`ifdef ALU_OVF_EN
      chk("ovf_reset", {7'd0, ovf_flag}, 8'd0);
      do_load(2'd0, 4'b0111);
      do_load(2'd1, 4'b0001);
      do_alu(3'd0, 2'd2, 2'd0, 2'd1, 4'b0111, 4'b0001);
      reg_chk("ovf_r2", 2'd2, 4'b1000);
      chk("ovf_set", {7'd0, ovf_flag}, 8'd1);
      do_alu(3'd2, 2'd3, 2'd0, 2'd1, 4'b0111, 4'b0001);
      chk("ovf_hold", {7'd0, ovf_flag}, 8'd1);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
